fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter sharing one synchronous FIFO write port among NUM_REQ producers.
//  Sits directly in front of the FIFO: muxes requester data onto data_in/wr_en and never issues a write the FIFO cannot take.
//  Routes the FIFO wr_ack/overflow response back to the requester that owned the write.
//  Keeps a saturating stall counter for coverage and scoreboard use.
// PARAMETERS
//  NUM_REQ     4    number of requesters (2..8)
//  DATA_WIDTH  16   FIFO word width
//  STALL_W     16   width of stall_cnt
// PORTS
//  clk              in   1                    system clock, all logic on posedge
//  rst_n            in   1                    asynchronous active-low reset
//  req              in   NUM_REQ              per-requester write request, level
//  req_data         in   NUM_REQ*DATA_WIDTH   requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//  gnt              out  NUM_REQ              one-hot grant, registered, 1-cycle pulse
//  ack              out  NUM_REQ              one-hot write acknowledge, decoded from FIFO wr_ack
//  err_ovf          out  NUM_REQ              sticky: FIFO flagged overflow on this requester's write
//  fifo_data_in     out  DATA_WIDTH           to FIFO data_in, registered
//  fifo_wr_en       out  1                    to FIFO wr_en, registered
//  fifo_full        in   1                    FIFO full
//  fifo_almostfull  in   1                    FIFO almostfull (one slot left)
//  fifo_wr_ack      in   1                    FIFO wr_ack (cycle after wr_en sampled)
//  fifo_overflow    in   1                    FIFO overflow (cycle after wr_en sampled)
//  stall_cnt        out  STALL_W              cycles with |req=1 but issue blocked, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): gnt=0, fifo_wr_en=0, fifo_data_in=0, err_ovf=0, stall_cnt=0.
//    rr_ptr=0 and the owner pipe are cleared; a write in flight at reset is dropped and produces no ack.
//  - can_issue = !fifo_full && !(fifo_almostfull && fifo_wr_en).
//    The second term covers the last slot: full does not yet reflect the write currently on the bus.
//  - Every posedge with |req && can_issue: pick the first set req[i] scanning from rr_ptr upward mod NUM_REQ.
//    Register gnt=onehot(i), fifo_wr_en=1, fifo_data_in=req_data slice i, then rr_ptr <= (i+1) mod NUM_REQ.
//    Otherwise gnt=0, fifo_wr_en=0, fifo_data_in holds its last value, rr_ptr unchanged.
//  - Latency: req sampled at edge t -> gnt and fifo_wr_en high during cycle t..t+1. Max one grant per cycle.
//  - Handshake: requester holds req and data stable until it sees gnt[i]=1.
//    On that posedge it may drop req or present the next word.
//    A req dropped before grant is a legal withdrawal; nothing is written.
//  - Owner pipe: when fifo_wr_en=1 at a posedge, own_v<=1 and own_idx<=granted index; else own_v<=0.
//  - ack[i] = fifo_wr_ack && own_v && own_idx==i (combinational).
//    A fifo_wr_ack with own_v=0 is ignored.
//  - err_ovf[own_idx] <= 1 on posedge when fifo_overflow && own_v. Cleared by reset only.
//    It must stay 0 in normal operation because the arbiter never writes into a full FIFO.
//  - stall_cnt += 1 on posedge when |req && !can_issue. Holds at 2^STALL_W-1.
//  - Fairness: a continuously requesting input is granted within NUM_REQ issue slots.
//  - NUM_REQ=1 degenerates to a pass-through with the full guard; rr_ptr stays 0.
// TESTING
//  Assumes an 8-deep FIFO, NUM_REQ=4, DATA_WIDTH=16.
//  1. Reset then req=4'b0001, data0=16'hA5A5:
//     -> next cycle gnt=0001, fifo_wr_en=1, fifo_data_in=A5A5; following cycle ack=0001.
//  2. req=4'b1111 held 8 cycles, empty FIFO:
//     -> gnt order 0001,0010,0100,1000,0001,... one per cycle.
//     -> 8 writes issued, then fifo_wr_en=0, full=1, stall_cnt increments; err_ovf=0.
//  3. Last slot: FIFO holds 7 words (almostfull=1), req=4'b0011:
//     -> exactly one grant; no write in the next cycle (guard); overflow never asserts.
//  4. Full FIFO with req=4'b0100, reader pops 1 word:
//     -> grant to requester 2 in the cycle after full deasserts.
//     -> stall_cnt equals the number of blocked cycles.
//  5. Reset mid-burst (rst_n low while fifo_wr_en=1):
//     -> all outputs 0 immediately; no ack for the in-flight write; after release rr_ptr=0.
//  6. Force fifo_overflow=1 with own_v=1, own_idx=3:
//     -> err_ovf=1000 and it stays set until reset.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the requester-side and FIFO-side signals around the write-port arbiter.
// master: the arbiter itself. slave: requesters plus the FIFO.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STALL_W    = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            err_ovf;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_wr_en;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic [STALL_W-1:0]            stall_cnt;

  modport master (
    input  req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output gnt, ack, err_ovf, fifo_data_in, fifo_wr_en, stall_cnt
  );

  modport slave (
    output req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  gnt, ack, err_ovf, fifo_data_in, fifo_wr_en, stall_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ producers.
// Never issues a write the FIFO cannot take, routes wr_ack/overflow back to the owner
// of the write, and counts stalled cycles (saturating).
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STALL_W    = 16
) (
  input logic               clk,
  input logic               rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                  can_issue;
  logic                  issue;
  logic                  found;
  logic [IdxW-1:0]       pick;
  logic [IdxW-1:0]       cand_idx;
  int unsigned           cand;

  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]       gnt_idx_q;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  own_v_q;
  logic [IdxW-1:0]       own_idx_q;
  logic [NUM_REQ-1:0]    err_ovf_q, err_ovf_d;
  logic [STALL_W-1:0]    stall_q, stall_d;

  // The almostfull term covers the last slot: full lags the write currently on the bus.
  assign can_issue = !bus.fifo_full && !(bus.fifo_almostfull && wr_en_q);
  assign issue     = (|bus.req) && can_issue;

  // Round-robin pick: first set request scanning upward from rr_ptr.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!found && bus.req[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  // Next-state for grant, data, pointer, sticky overflow and stall counter.
  always_comb begin
    gnt_d     = '0;
    data_d    = data_q;
    rr_ptr_d  = rr_ptr_q;
    err_ovf_d = err_ovf_q;
    stall_d   = stall_q;
    if (issue) begin
      gnt_d[pick] = 1'b1;
      data_d      = bus.req_data[32'(pick)*DATA_WIDTH +: DATA_WIDTH];
      rr_ptr_d    = IdxW'((32'(pick) + 1) % NUM_REQ);
    end
    if (bus.fifo_overflow && own_v_q) begin
      err_ovf_d[own_idx_q] = 1'b1;
    end
    if ((|bus.req) && !can_issue && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // State registers; reset drops any write in flight by clearing the owner pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      own_v_q   <= 1'b0;
      own_idx_q <= '0;
      err_ovf_q <= '0;
      stall_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= issue ? pick : gnt_idx_q;
      gnt_q     <= gnt_d;
      wr_en_q   <= issue;
      data_q    <= data_d;
      own_v_q   <= wr_en_q;
      own_idx_q <= gnt_idx_q;
      err_ovf_q <= err_ovf_d;
      stall_q   <= stall_d;
    end
  end

  // Acknowledge decoded to the requester that owned the write one cycle earlier.
  always_comb begin
    bus.ack = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.ack[i] = bus.fifo_wr_ack && own_v_q && (own_idx_q == IdxW'(i));
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_data_in = data_q;
  assign bus.err_ovf      = err_ovf_q;
  assign bus.stall_cnt    = stall_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with an 8-deep FIFO occupancy model on the far side.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16), .STALL_W(16)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .STALL_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: occupancy reset to init_cnt; responses registered and not cleared by rst_n.
  int   init_cnt = 0;
  int   cnt;
  logic pop = 1'b0;
  logic force_ovf = 1'b0;
  logic wr_ack_q = 1'b0;
  logic ovf_q = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= init_cnt;
    else cnt <= cnt + ((bus.fifo_wr_en && cnt < 8) ? 1 : 0) - ((pop && cnt > 0) ? 1 : 0);
  end

  always @(posedge clk) begin
    wr_ack_q <= bus.fifo_wr_en && (cnt < 8);
    ovf_q    <= bus.fifo_wr_en && (cnt >= 8);
  end

  assign bus.fifo_full       = (cnt >= 8);
  assign bus.fifo_almostfull = (cnt == 7);
  assign bus.fifo_wr_ack     = wr_ack_q;
  assign bus.fifo_overflow   = ovf_q | force_ovf;

  logic [15:0] dv [4];

  task automatic set_data();
    bus.req_data = {dv[3], dv[2], dv[1], dv[0]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int fill);
    bus.req   = '0;
    pop       = 1'b0;
    force_ovf = 1'b0;
    init_cnt  = fill;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    dv[0] = 16'hA5A5; dv[1] = 16'h1111; dv[2] = 16'h2222; dv[3] = 16'h3333;
    set_data();
    do_reset(0);
    n_total++;
    if ({bus.gnt, bus.fifo_wr_en, bus.ack} !== 9'b0)
      $display("FAIL reset_ctrl got gnt=%b wr_en=%b ack=%b exp all 0", bus.gnt, bus.fifo_wr_en, bus.ack);
    else n_pass++;
    n_total++;
    if ({bus.fifo_data_in, bus.err_ovf, bus.stall_cnt} !== 36'b0)
      $display("FAIL reset_state got data=%h err=%b stall=%0d exp 0", bus.fifo_data_in, bus.err_ovf, bus.stall_cnt);
    else n_pass++;
  endtask

  task automatic test_single();
    bus.req = 4'b0001;
    step();
    n_total++;
    if ({bus.gnt, bus.fifo_wr_en, bus.fifo_data_in} !== {4'b0001, 1'b1, 16'hA5A5})
      $display("FAIL single_grant got gnt=%b wr_en=%b data=%h exp 0001/1/a5a5", bus.gnt, bus.fifo_wr_en, bus.fifo_data_in);
    else n_pass++;
    bus.req = 4'b0000;
    step();
    n_total++;
    if ({bus.ack, bus.gnt, bus.fifo_wr_en} !== {4'b0001, 4'b0000, 1'b0})
      $display("FAIL single_ack got ack=%b gnt=%b wr_en=%b exp 0001/0000/0", bus.ack, bus.gnt, bus.fifo_wr_en);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0]  eg, ea;
    logic        ew;
    logic [15:0] es;
    dv[0] = 16'hA000; dv[1] = 16'hB001; dv[2] = 16'hC002; dv[3] = 16'hD003;
    set_data();
    do_reset(0);
    bus.req = 4'b1111;
    for (int k = 1; k <= 11; k++) begin
      step();
      eg = (k <= 8) ? 4'(1 << ((k - 1) % 4)) : 4'b0000;
      ew = (k <= 8);
      ea = (k >= 2 && k <= 9) ? 4'(1 << ((k - 2) % 4)) : 4'b0000;
      es = (k <= 8) ? 16'd0 : 16'(k - 8);
      n_total++;
      if ({bus.gnt, bus.fifo_wr_en} !== {eg, ew})
        $display("FAIL rr_gnt[%0d] got gnt=%b wr_en=%b exp %b/%b", k, bus.gnt, bus.fifo_wr_en, eg, ew);
      else n_pass++;
      n_total++;
      if (bus.ack !== ea)
        $display("FAIL rr_ack[%0d] got %b exp %b", k, bus.ack, ea);
      else n_pass++;
      n_total++;
      if (bus.stall_cnt !== es)
        $display("FAIL rr_stall[%0d] got %0d exp %0d", k, bus.stall_cnt, es);
      else n_pass++;
      n_total++;
      if (bus.fifo_data_in !== dv[(k <= 8) ? (k - 1) % 4 : 3])
        $display("FAIL rr_data[%0d] got %h exp %h", k, bus.fifo_data_in, dv[(k <= 8) ? (k - 1) % 4 : 3]);
      else n_pass++;
    end
    n_total++;
    if (bus.err_ovf !== 4'b0000)
      $display("FAIL rr_err_ovf got %b exp 0000", bus.err_ovf);
    else n_pass++;
    bus.req = 4'b0000;
  endtask

  task automatic test_last_slot();
    do_reset(7);
    bus.req = 4'b0011;
    step();
    n_total++;
    if ({bus.gnt, bus.fifo_wr_en} !== {4'b0001, 1'b1})
      $display("FAIL last_grant got gnt=%b wr_en=%b exp 0001/1", bus.gnt, bus.fifo_wr_en);
    else n_pass++;
    bus.req = 4'b0010;
    step();
    n_total++;
    if ({bus.gnt, bus.fifo_wr_en, bus.ack} !== {4'b0000, 1'b0, 4'b0001})
      $display("FAIL last_guard got gnt=%b wr_en=%b ack=%b exp 0000/0/0001", bus.gnt, bus.fifo_wr_en, bus.ack);
    else n_pass++;
    step();
    step();
    n_total++;
    if ({bus.fifo_wr_en, bus.stall_cnt} !== {1'b0, 16'd3})
      $display("FAIL last_stall got wr_en=%b stall=%0d exp 0/3", bus.fifo_wr_en, bus.stall_cnt);
    else n_pass++;
    n_total++;
    if ({bus.err_ovf, bus.fifo_overflow} !== 5'b0)
      $display("FAIL last_no_ovf got err=%b ovf=%b exp 0000/0", bus.err_ovf, bus.fifo_overflow);
    else n_pass++;
    bus.req = 4'b0000;
  endtask

  task automatic test_full_pop();
    dv[0] = 16'h0F00; dv[1] = 16'h0F11; dv[2] = 16'h0F22; dv[3] = 16'h0F33;
    set_data();
    do_reset(8);
    bus.req = 4'b0100;
    step(); step(); step();
    n_total++;
    if ({bus.gnt, bus.stall_cnt} !== {4'b0000, 16'd3})
      $display("FAIL full_block got gnt=%b stall=%0d exp 0000/3", bus.gnt, bus.stall_cnt);
    else n_pass++;
    pop = 1'b1;
    step();
    pop = 1'b0;
    n_total++;
    if ({bus.gnt, bus.stall_cnt, bus.fifo_full} !== {4'b0000, 16'd4, 1'b0})
      $display("FAIL full_pop got gnt=%b stall=%0d full=%b exp 0000/4/0", bus.gnt, bus.stall_cnt, bus.fifo_full);
    else n_pass++;
    step();
    n_total++;
    if ({bus.gnt, bus.fifo_wr_en, bus.fifo_data_in, bus.stall_cnt} !== {4'b0100, 1'b1, 16'h0F22, 16'd4})
      $display("FAIL full_grant got gnt=%b wr_en=%b data=%h stall=%0d exp 0100/1/0f22/4", bus.gnt, bus.fifo_wr_en, bus.fifo_data_in, bus.stall_cnt);
    else n_pass++;
    bus.req = 4'b0000;
  endtask

  task automatic test_mid_reset();
    do_reset(0);
    bus.req = 4'b1111;
    step();
    step();
    n_total++;
    if ({bus.gnt, bus.ack} !== {4'b0010, 4'b0001})
      $display("FAIL mid_pre got gnt=%b ack=%b exp 0010/0001", bus.gnt, bus.ack);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.gnt, bus.fifo_wr_en, bus.ack, bus.fifo_data_in, bus.err_ovf, bus.stall_cnt} !== 45'b0)
      $display("FAIL mid_async got gnt=%b wr_en=%b ack=%b data=%h exp all 0", bus.gnt, bus.fifo_wr_en, bus.ack, bus.fifo_data_in);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    step();
    n_total++;
    if ({bus.gnt, bus.ack} !== {4'b0001, 4'b0000})
      $display("FAIL mid_rrptr got gnt=%b ack=%b exp 0001/0000", bus.gnt, bus.ack);
    else n_pass++;
    bus.req = 4'b0000;
  endtask

  task automatic test_overflow_sticky();
    do_reset(0);
    bus.req = 4'b1000;
    step();
    bus.req   = 4'b0000;
    force_ovf = 1'b1;
    step();
    n_total++;
    if ({bus.err_ovf, bus.ack} !== {4'b0000, 4'b1000})
      $display("FAIL ovf_early got err=%b ack=%b exp 0000/1000", bus.err_ovf, bus.ack);
    else n_pass++;
    step();
    force_ovf = 1'b0;
    n_total++;
    if (bus.err_ovf !== 4'b1000)
      $display("FAIL ovf_set got %b exp 1000", bus.err_ovf);
    else n_pass++;
    step(); step(); step();
    n_total++;
    if (bus.err_ovf !== 4'b1000)
      $display("FAIL ovf_sticky got %b exp 1000", bus.err_ovf);
    else n_pass++;
    do_reset(0);
    n_total++;
    if (bus.err_ovf !== 4'b0000)
      $display("FAIL ovf_clear got %b exp 0000", bus.err_ovf);
    else n_pass++;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_last_slot();
    test_full_pop();
    test_mid_reset();
    test_overflow_sticky();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
